upload_frame_packer: RTL

UPLOAD_FRAME_PACKER -- requirements
Module: upload_frame_packer

---
 rtl/upload_frame_packer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/upload_frame_packer.sv
`default_nettype none
// ============================================================================
// Module   : upload_frame_packer
// Purpose  : Buffers an I2C read burst and emits it as a framed byte stream:
//            HDR0 HDR1 cmd len_h len_l payload [checksum].
//            Optional checksum byte enabled by macro UPLOAD_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module upload_frame_packer #(
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] HDR0       = 8'hAA,
    parameter logic [7:0] HDR1       = 8'h44
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] src_cmd,
    input  logic [7:0] src_data,
    input  logic       src_valid,
    input  logic       src_last,
    output logic       src_ready,
    output logic [7:0] upload_data,
    output logic       upload_valid,
    input  logic       upload_ready
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_LAST_IDX = c_CNT_W'(FIFO_DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] S_HDR0    = 3'd1;
    localparam logic [2:0] S_HDR1    = 3'd2;
    localparam logic [2:0] S_CMD     = 3'd3;
    localparam logic [2:0] S_LENH    = 3'd4;
    localparam logic [2:0] S_LENL    = 3'd5;
    localparam logic [2:0] S_PAYLOAD = 3'd6;
`ifdef UPLOAD_CHECKSUM_EN
    localparam logic [2:0] S_CSUM    = 3'd7;
`endif

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] r_pop;
    logic [7:0]         r_cmd;
    logic               r_live;
`ifdef UPLOAD_CHECKSUM_EN
    logic [7:0]         r_sum;
    logic [7:0]         w_csum;
`endif

    logic w_accept;
    logic w_close;
    logic w_hs;
    logic w_last_pop;
    logic w_frame_done;

    assign w_accept     = src_valid && src_ready;
    // A burst closes on src_last or when the buffer's final slot is filled.
    assign w_close      = w_accept && (src_last || (r_count == c_LAST_IDX));
    assign w_hs         = upload_valid && upload_ready;
    assign w_last_pop   = ((r_pop + c_CNT_ONE) == r_count);
    assign w_frame_done = (r_state != IDLE) && (w_next == IDLE);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (w_close) w_next = S_HDR0;
            S_HDR0:    if (w_hs)    w_next = S_HDR1;
            S_HDR1:    if (w_hs)    w_next = S_CMD;
            S_CMD:     if (w_hs)    w_next = S_LENH;
            S_LENH:    if (w_hs)    w_next = S_LENL;
            S_LENL:    if (w_hs)    w_next = S_PAYLOAD;
            S_PAYLOAD: begin
                if (w_hs && w_last_pop) begin
`ifdef UPLOAD_CHECKSUM_EN
                    w_next = S_CSUM;
`else
                    w_next = IDLE;
`endif
                end
            end
`ifdef UPLOAD_CHECKSUM_EN
            S_CSUM:    if (w_hs)    w_next = IDLE;
`endif
            default:                w_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
`ifdef UPLOAD_CHECKSUM_EN
    // len_h is always zero, so it contributes nothing to the sum.
    assign w_csum = r_cmd + 8'(r_count) + r_sum;
`endif

    always_comb begin
        src_ready    = (r_state == IDLE) && r_live;
        upload_valid = (r_state != IDLE);
        upload_data  = 8'h00;
        case (r_state)
            S_HDR0:    upload_data = HDR0;
            S_HDR1:    upload_data = HDR1;
            S_CMD:     upload_data = r_cmd;
            S_LENH:    upload_data = 8'h00;
            S_LENL:    upload_data = 8'(r_count);
            S_PAYLOAD: upload_data = r_mem[r_rd_ptr];
`ifdef UPLOAD_CHECKSUM_EN
            S_CSUM:    upload_data = w_csum;
`endif
            default:   upload_data = 8'h00;
        endcase
    end

    // ------------------------------------------------------------------
    // Payload buffer storage (contents need no reset; pointers do)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= src_data;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, counters, command capture and running sum
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live   <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_pop    <= '0;
            r_cmd    <= 8'h00;
`ifdef UPLOAD_CHECKSUM_EN
            r_sum    <= 8'h00;
`endif
        end else begin
            r_live <= 1'b1;
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                r_count  <= r_count + c_CNT_ONE;
                if (r_count == '0) begin
                    r_cmd <= src_cmd;
                end
`ifdef UPLOAD_CHECKSUM_EN
                r_sum <= r_sum + src_data;
`endif
            end
            if ((r_state == S_PAYLOAD) && w_hs) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                r_pop    <= r_pop + c_CNT_ONE;
            end
            // The whole buffer drains every frame, so restart from slot 0.
            if (w_frame_done) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_pop    <= '0;
`ifdef UPLOAD_CHECKSUM_EN
                r_sum    <= 8'h00;
`endif
            end
        end
    end

endmodule
`default_nettype wire
